// File: rtl/traffic_phase_ctrl_if.sv
// Detect inputs, lamp outputs and status of the NS/EW phase scheduler.
// The master side drives the detects; traffic_phase_ctrl connects to the slave side.
interface traffic_phase_ctrl_if #(
    parameter int TW = 5
);
    logic          i_NS_vehicle_detect;
    logic          i_EW_vehicle_detect;
    logic          NS_red;
    logic          NS_green;
    logic          NS_yellow;
    logic          EW_red;
    logic          EW_green;
    logic          EW_yellow;
    logic [2:0]    o_phase;
    logic [TW-1:0] o_phase_timer;
    logic          o_ns_req;
    logic          o_ew_req;

    modport master (
        output i_NS_vehicle_detect, i_EW_vehicle_detect,
        input  NS_red, NS_green, NS_yellow, EW_red, EW_green, EW_yellow,
        input  o_phase, o_phase_timer, o_ns_req, o_ew_req
    );

    modport slave (
        input  i_NS_vehicle_detect, i_EW_vehicle_detect,
        output NS_red, NS_green, NS_yellow, EW_red, EW_green, EW_yellow,
        output o_phase, o_phase_timer, o_ns_req, o_ew_req
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Single-FSM NS/EW phase scheduler with demand latches and one shared phase timer.
// Define ALL_RED_EN to insert the all-red clearance states between yellow and the opposing green.
module traffic_phase_ctrl #(
    parameter int TW           = 5,
    parameter int GREEN_MIN    = 4,
    parameter int NS_GREEN_MAX = 16,
    parameter int EW_GREEN_MAX = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2
) (
    input logic                 i_clk,
    input logic                 i_rst,
    traffic_phase_ctrl_if.slave bus
);

    localparam int TMAX = 2 ** TW;

    // Durations count timer values 0..N-1, so each must fit in the TW-bit timer.
    if (GREEN_MIN < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
        GREEN_MIN > NS_GREEN_MAX || GREEN_MIN > EW_GREEN_MAX ||
        NS_GREEN_MAX > TMAX || EW_GREEN_MAX > TMAX ||
        YELLOW_TIME > TMAX || ALL_RED_TIME > TMAX) begin : g_bad_params
        $fatal(1, "traffic_phase_ctrl: illegal timing parameter set");
    end

    localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_NSMAX  = TW'(NS_GREEN_MAX - 1);
    localparam logic [TW-1:0] T_EWMAX  = TW'(EW_GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL    = TW'(YELLOW_TIME - 1);
`ifdef ALL_RED_EN
    localparam logic [TW-1:0] T_AR     = TW'(ALL_RED_TIME - 1);
`endif
    localparam logic [TW-1:0] TIMER_SAT = '1;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_NS2EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_EW2NS = 3'd5
    } phase_t;

    phase_t        state;
    phase_t        state_next;
    logic [TW-1:0] timer;
    logic          ns_req;
    logic          ew_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= NS_GREEN;
            timer  <= '0;
            ns_req <= 1'b0;
            ew_req <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (timer != TIMER_SAT)
                timer <= timer + 1'b1;

            // Entering the served green consumes the demand, even if detect is still high.
            if (state_next == NS_GREEN && state != NS_GREEN)
                ns_req <= 1'b0;
            else if (bus.i_NS_vehicle_detect && state != NS_GREEN)
                ns_req <= 1'b1;

            if (state_next == EW_GREEN && state != EW_GREEN)
                ew_req <= 1'b0;
            else if (bus.i_EW_vehicle_detect && state != EW_GREEN)
                ew_req <= 1'b1;
        end
    end

    // Green ends only for a waiting opponent; own demand keeps it up to the max.
    always_comb begin
        state_next = state;
        case (state)
            NS_GREEN:
                if (timer >= T_GMIN && ew_req &&
                    (!bus.i_NS_vehicle_detect || timer >= T_NSMAX))
                    state_next = NS_YELLOW;
            NS_YELLOW:
                if (timer == T_YEL)
`ifdef ALL_RED_EN
                    state_next = RED_NS2EW;
`else
                    state_next = EW_GREEN;
`endif
            EW_GREEN:
                if (timer >= T_GMIN && ns_req &&
                    (!bus.i_EW_vehicle_detect || timer >= T_EWMAX))
                    state_next = EW_YELLOW;
            EW_YELLOW:
                if (timer == T_YEL)
`ifdef ALL_RED_EN
                    state_next = RED_EW2NS;
`else
                    state_next = NS_GREEN;
`endif
`ifdef ALL_RED_EN
            RED_NS2EW:
                if (timer == T_AR)
                    state_next = EW_GREEN;
            RED_EW2NS:
                if (timer == T_AR)
                    state_next = NS_GREEN;
`endif
            default:
                state_next = NS_GREEN;
        endcase
    end

    // Moore lamp decode; anything not serving an approach leaves it red.
    always_comb begin
        bus.NS_red    = 1'b1;
        bus.NS_green  = 1'b0;
        bus.NS_yellow = 1'b0;
        bus.EW_red    = 1'b1;
        bus.EW_green  = 1'b0;
        bus.EW_yellow = 1'b0;
        case (state)
            NS_GREEN: begin
                bus.NS_red   = 1'b0;
                bus.NS_green = 1'b1;
            end
            NS_YELLOW: begin
                bus.NS_red    = 1'b0;
                bus.NS_yellow = 1'b1;
            end
            EW_GREEN: begin
                bus.EW_red   = 1'b0;
                bus.EW_green = 1'b1;
            end
            EW_YELLOW: begin
                bus.EW_red    = 1'b0;
                bus.EW_yellow = 1'b1;
            end
            default: begin
                bus.NS_red = 1'b1;
                bus.EW_red = 1'b1;
            end
        endcase
    end

    assign bus.o_phase       = state;
    assign bus.o_phase_timer = timer;
    assign bus.o_ns_req      = ns_req;
    assign bus.o_ew_req      = ew_req;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Single-FSM phase scheduler for the two-approach (NS/EW) intersection. Replaces the free-running NS/EW/yellow counters with one internal phase timer. Arbitrates right-of-way between the two approaches from vehicle-detect demand, using min/max green, fixed yellow and optional all-red clearance. Drives the six lamp outputs that feed the signal heads.

Parameters:
TW, 5, phase timer width in bits
GREEN_MIN, 4, minimum green duration in cycles, both approaches (>=1)
NS_GREEN_MAX, 16, NS green duration in cycles when the other approach is waiting and NS demand persists
EW_GREEN_MAX, 10, EW green duration in cycles, same rule as NS_GREEN_MAX
YELLOW_TIME, 3, yellow duration in cycles (>=1)
ALL_RED_TIME, 2, all-red clearance duration in cycles (>=1; used only with ALL_RED_EN)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_NS_vehicle_detect  input  1  NS vehicle present (level)
i_EW_vehicle_detect  input  1  EW vehicle present (level)
NS_red  output  1  NS red lamp
NS_green  output  1  NS green lamp
NS_yellow  output  1  NS yellow lamp
EW_red  output  1  EW red lamp
EW_green  output  1  EW green lamp
EW_yellow  output  1  EW yellow lamp
o_phase  output  3  current state encoding
o_phase_timer  output  TW  cycles elapsed in current state
o_ns_req  output  1  latched NS demand
o_ew_req  output  1  latched EW demand

Behaviour:
- Reset is synchronous and active-high. In a cycle where i_rst=1, next state is NS_GREEN, timer=0 and both demand latches are cleared. A reset in mid-phase (any state) applies the same rule.
- Reset outputs: NS_green=1, EW_red=1, all other lamps 0. o_phase=0, o_phase_timer=0, o_ns_req=0, o_ew_req=0.
- State encoding: 0 NS_GREEN, 1 NS_YELLOW, 2 RED_NS2EW, 3 EW_GREEN, 4 EW_YELLOW, 5 RED_EW2NS. Codes 6 and 7 are illegal; they recover to NS_GREEN on the next cycle.
- Lamps are a Moore decode of the state register. In each state, exactly one lamp per approach is lit.
  - The non-serving approach shows red.
  - States 2 and 5 show red on both approaches.
- Timer:
  - Cleared on every state change.
  - Otherwise increments by 1 per cycle and saturates at 2^TW-1.
  - Timer value k means the state has been held for k+1 cycles.
- Demand latches:
  - ew_req is set when i_EW_vehicle_detect=1 in any state other than EW_GREEN.
  - ew_req is cleared on the transition into EW_GREEN. Clearing takes priority over setting in that same cycle.
  - ns_req is symmetric with respect to NS_GREEN.
- Transitions (evaluated each cycle, taking effect at the next edge):
  - NS_GREEN -> NS_YELLOW when timer>=GREEN_MIN-1 AND ew_req AND (i_NS_vehicle_detect=0 OR timer>=NS_GREEN_MAX-1).
  - Without ew_req, NS rests in green indefinitely.
  - EW_GREEN -> EW_YELLOW uses the mirror rule with EW_GREEN_MAX and ns_req.
  - NS_YELLOW -> RED_NS2EW when timer==YELLOW_TIME-1. EW_YELLOW -> RED_EW2NS under the same condition.
  - RED_NS2EW -> EW_GREEN when timer==ALL_RED_TIME-1. RED_EW2NS -> NS_GREEN under the same condition.
- A yellow is never cut short or extended by detect activity.
- Safety invariant: NS and EW are never both non-red in the same cycle.
- When both approaches demand continuously, the cycle period is NS_GREEN_MAX + EW_GREEN_MAX + 2*YELLOW_TIME + 2*ALL_RED_TIME.
- Parameter legality is checked at elaboration; an illegal value is a fatal error:
  - GREEN_MIN <= each *_GREEN_MAX.
  - Every duration <= 2^TW.

Optional Feature:
ALL_RED_EN:
- Defined: states 2 and 5 are present, as described above.
- Undefined: states 2 and 5 are never entered. NS_YELLOW goes directly to EW_GREEN and EW_YELLOW goes directly to NS_GREEN when timer==YELLOW_TIME-1. ALL_RED_TIME is ignored.
- Both-demand period is then NS_GREEN_MAX + EW_GREEN_MAX + 2*YELLOW_TIME.

Test Plan:
1. Reset, both detects 0 for 100 cycles -> NS_green=1, EW_red=1 throughout; o_phase=0; o_phase_timer saturates at 31.
2. Single-cycle EW detect pulse at cycle 20 after reset, NS detect 0 -> o_ew_req=1 next cycle; NS_yellow for 3 cycles; both red for 2 cycles (ALL_RED_EN); then EW_green=1 and o_ew_req=0; EW rests in green with no NS demand.
3. Both detects held at 1 -> NS_green 16 cycles, yellow 3, all-red 2, EW_green 10, yellow 3, all-red 2; period 36 (32 without ALL_RED_EN).
4. NS detect held at 1, EW detect asserted at cycle 2 then dropped -> NS green lasts the full 16 cycles; then the EW phase is served once; control returns to NS via ns_req.
5. NS detect pulse during EW_YELLOW (EW served) -> o_ns_req set; NS_GREEN reached with no extra green cycles inserted. Then i_rst=1 asserted mid-phase for 1 cycle -> next cycle is the reset output state with latches 0.
6. 10k cycles of random detects -> the safety invariant and lamp one-hot-per-approach hold every cycle; every yellow lasts exactly 3 cycles.
